gpio_key_debounce: RTL and testbench

//  Conditions raw push-button inputs for the EMPU GPIO input bus (gpioin[15:0]).

---
 rtl/gpio_key_debounce.sv | 86 ++++++++
 tb/tb_gpio_key_debounce.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_key_debounce.sv
// Key conditioner for the EMPU GPIO input bus: two-flop synchroniser, per-key debounce
// counter, registered press strobe and a sticky press flag that firmware clears via evt_clr_i.
module gpio_key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                sys_clk_i,
    input  logic                reset_n_i,
    input  logic [NUM_KEYS-1:0] key_i,
    input  logic [NUM_KEYS-1:0] evt_clr_i,
    output logic [NUM_KEYS-1:0] key_level_o,
    output logic [NUM_KEYS-1:0] key_pulse_o,
    output logic [NUM_KEYS-1:0] key_press_o,
    output logic [15:0]         gpioin_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0] PIN_RELEASED = ACTIVE_LOW ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

    if (2 * NUM_KEYS > 16) begin : g_bad_num_keys
        $error("gpio_key_debounce: 2*NUM_KEYS must not exceed 16");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("gpio_key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] accept;
    logic [NUM_KEYS-1:0] press_set;

    // Sync flops reset to the released pin level so leaving reset never looks like a press.
    always_ff @(posedge sys_clk_i) begin
        if (!reset_n_i) begin
            sync1 <= PIN_RELEASED;
            sync2 <= PIN_RELEASED;
        end else begin
            sync1 <= key_i;
            sync2 <= sync1;
        end
    end

    assign raw = ACTIVE_LOW ? ~sync2 : sync2;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [CNT_W-1:0] cnt;

        assign accept[k] = (raw[k] != key_level_o[k]) && (cnt == CNT_LAST);

        // Any sample that agrees with the accepted level restarts the count.
        always_ff @(posedge sys_clk_i) begin
            if (!reset_n_i) begin
                cnt <= '0;
            end else if (raw[k] == key_level_o[k] || accept[k]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press_set = accept & raw;

    // A set in the same cycle as a clear wins, so no press is lost.
    always_ff @(posedge sys_clk_i) begin
        if (!reset_n_i) begin
            key_level_o <= '0;
            key_pulse_o <= '0;
            key_press_o <= '0;
        end else begin
            key_level_o <= key_level_o ^ accept;
            key_pulse_o <= press_set;
            key_press_o <= (key_press_o & ~evt_clr_i) | press_set;
        end
    end

    always_comb begin
        gpioin_o = '0;
        gpioin_o[NUM_KEYS-1:0]          = key_level_o;
        gpioin_o[2*NUM_KEYS-1:NUM_KEYS] = key_press_o;
    end

endmodule

// File: tb/tb_gpio_key_debounce.sv
// Bench for gpio_key_debounce with two active-low keys and an 8-cycle debounce window.
module tb_gpio_key_debounce;

    localparam int NUM_KEYS = 2;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int W = 16 + 3 * NUM_KEYS;

    logic                sys_clk_i = 1'b0;
    logic                reset_n_i;
    logic [NUM_KEYS-1:0] key_i;
    logic [NUM_KEYS-1:0] evt_clr_i;
    logic [NUM_KEYS-1:0] key_level_o;
    logic [NUM_KEYS-1:0] key_pulse_o;
    logic [NUM_KEYS-1:0] key_press_o;
    logic [15:0]         gpioin_o;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got;
    logic [W-1:0] want;
    int checks = 0;
    int failures = 0;

    gpio_key_debounce #(
        .NUM_KEYS(NUM_KEYS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk_i(sys_clk_i),
        .reset_n_i(reset_n_i),
        .key_i(key_i),
        .evt_clr_i(evt_clr_i),
        .key_level_o(key_level_o),
        .key_pulse_o(key_pulse_o),
        .key_press_o(key_press_o),
        .gpioin_o(gpioin_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    // Expected observation vector: {gpioin, press, pulse, level}, gpioin built from the bit map.
    function automatic logic [W-1:0] mk(input logic [1:0] lv, input logic [1:0] pu, input logic [1:0] pr);
        logic [15:0] g;
        g = {12'h000, pr, lv};
        return {g, pr, pu, lv};
    endfunction

    task automatic test_reset();
        reset_n_i = 1'b0;
        key_i = 2'b11;
        evt_clr_i = 2'b00;
        for (int c = 1; c <= 103; c++) begin
            if (c == 4) reset_n_i = 1'b1;
            exp_q.push_back(mk(2'b00, 2'b00, 2'b00));
            @(posedge sys_clk_i);
            @(negedge sys_clk_i);
            got = {gpioin_o, key_press_o, key_pulse_o, key_level_o};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset cycle %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_clean_press();
        key_i = 2'b10;
        for (int c = 1; c <= 12; c++) begin
            exp_q.push_back(mk(c >= 10 ? 2'b01 : 2'b00, c == 10 ? 2'b01 : 2'b00, c >= 10 ? 2'b01 : 2'b00));
            @(posedge sys_clk_i);
            @(negedge sys_clk_i);
            got = {gpioin_o, key_press_o, key_pulse_o, key_level_o};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL clean_press cycle %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_bounce();
        int len1;
        int len2;
        len1 = $urandom_range(2, 6);
        len2 = $urandom_range(2, 6);
        for (int c = 1; c <= len1 + 1 + len2 + 12; c++) begin
            if (c <= len1) key_i = 2'b00;
            else if (c == len1 + 1) key_i = 2'b10;
            else if (c <= len1 + 1 + len2) key_i = 2'b00;
            else key_i = 2'b10;
            exp_q.push_back(mk(2'b01, 2'b00, 2'b01));
            @(posedge sys_clk_i);
            @(negedge sys_clk_i);
            got = {gpioin_o, key_press_o, key_pulse_o, key_level_o};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL bounce cycle %0d (lows %0d/%0d): got %h want %h", c, len1, len2, got, want);
            end
        end
    endtask

    task automatic test_clear();
        evt_clr_i = 2'b01;
        exp_q.push_back(mk(2'b01, 2'b00, 2'b00));
        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        evt_clr_i = 2'b00;
        got = {gpioin_o, key_press_o, key_pulse_o, key_level_o};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL clear_key0: got %h want %h", got, want);
        end
        // Key 1 press, with its clear asserted exactly on the accept edge.
        key_i = 2'b00;
        for (int c = 1; c <= 11; c++) begin
            evt_clr_i = (c == 10) ? 2'b10 : 2'b00;
            exp_q.push_back(mk(c >= 10 ? 2'b11 : 2'b01, c == 10 ? 2'b10 : 2'b00, c >= 10 ? 2'b10 : 2'b00));
            @(posedge sys_clk_i);
            @(negedge sys_clk_i);
            got = {gpioin_o, key_press_o, key_pulse_o, key_level_o};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL set_beats_clear cycle %0d: got %h want %h", c, got, want);
            end
        end
        evt_clr_i = 2'b00;
    endtask

    task automatic test_release();
        key_i = 2'b11;
        for (int c = 1; c <= 12; c++) begin
            exp_q.push_back(mk(c >= 10 ? 2'b00 : 2'b11, 2'b00, 2'b10));
            @(posedge sys_clk_i);
            @(negedge sys_clk_i);
            got = {gpioin_o, key_press_o, key_pulse_o, key_level_o};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL release cycle %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        key_i = 2'b10;
        for (int c = 1; c <= 18; c++) begin
            reset_n_i = (c == 6) ? 1'b0 : 1'b1;
            if (c <= 5) exp_q.push_back(mk(2'b00, 2'b00, 2'b10));
            else exp_q.push_back(mk(c >= 16 ? 2'b01 : 2'b00, c == 16 ? 2'b01 : 2'b00, c >= 16 ? 2'b01 : 2'b00));
            @(posedge sys_clk_i);
            @(negedge sys_clk_i);
            got = {gpioin_o, key_press_o, key_pulse_o, key_level_o};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_count cycle %0d: got %h want %h", c, got, want);
            end
        end
        reset_n_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_clear();
        test_release();
        test_reset_mid_count();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
